// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage (and/or/add/sub/slt) with a 2-entry skid buffer.
// Define OVERFLOW_DETECT_EN to add the per-entry signed overflow flag on out_ovf.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic             out_err,
`ifdef OVERFLOW_DETECT_EN
  output logic             out_ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is registered and never depends on out_ready in the same cycle.

`ifdef OVERFLOW_DETECT_EN
  localparam int OVF_W = 1;
`else
  localparam int OVF_W = 0;
`endif
  // Entry layout, LSB first: result, zero, err, then ovf when enabled.
  localparam int ENT_W = WIDTH + 2 + OVF_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [ENT_W-1:0] head, tail, ent_new;
  logic [WIDTH-1:0] res, sum, diff;
  logic             err;
  logic             accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;

  always_comb begin
    res = '0;
    err = 1'b0;
    case (in_op)
      3'b000:  res = in_a & in_b;
      3'b001:  res = in_a | in_b;
      3'b010:  res = sum;
      3'b110:  res = diff;
      3'b111:  res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: err = 1'b1;
    endcase
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    if (in_op == 3'b010)
      ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    else if (in_op == 3'b110)
      ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
  end

  assign ent_new = {ovf, err, (res == '0), res};
  assign out_ovf = head[WIDTH+2];
`else
  assign ent_new = {err, (res == '0), res};
`endif

  // State register; in_ready is precomputed from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !pop)      state_nx = TWO;
        else if (pop && !accept) state_nx = EMPTY;
      end
      TWO:     if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != EMPTY);
    dbg_state = state;
  end

  // Head always feeds the outputs; tail only holds the second entry in TWO.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) head <= ent_new;
        ONE: begin
          if (accept && pop) head <= ent_new;
          else if (accept)   tail <= ent_new;
        end
        TWO:     if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign out_z    = head[WIDTH-1:0];
  assign out_zero = head[WIDTH];
  assign out_err  = head[WIDTH+1];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_alu_exec_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic         out_valid, out_ready;
  logic [W-1:0] out_z;
  logic         out_zero, out_err;
  logic [1:0]   dbg_state;
`ifdef OVERFLOW_DETECT_EN
  logic         out_ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected entries: {ovf, err, zero, z}
  logic [W+2:0] exp_q[$];

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_zero(out_zero), .out_err(out_err),
`ifdef OVERFLOW_DETECT_EN
    .out_ovf(out_ovf),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    longint sa, sb, r;
    logic [W-1:0] z;
    logic err, ovf;
    sa = $signed(a);
    sb = $signed(b);
    r = 0;
    err = 1'b0;
    ovf = 1'b0;
    case (op)
      3'b000: z = a & b;
      3'b001: z = a | b;
      3'b010: begin z = a + b; r = sa + sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b110: begin z = a - b; r = sa - sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b111: z = (sa < sb) ? 32'd1 : 32'd0;
      default: begin z = '0; err = 1'b1; end
    endcase
    return {ovf, err, (z == 0), z};
  endfunction

  // Present one op for exactly one edge with out_ready held 1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_z !== 32'h0) $display("FAIL reset_out_z got %h exp 0", out_z); else pass_cnt++;
    total_cnt++; if ({out_zero, out_err} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {out_zero, out_err}); else pass_cnt++;
  endtask

  task automatic test_logic_ops();
    send(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000);
    @(negedge clk);
    total_cnt++; if ({out_valid, out_z} !== {1'b1, 32'h00F000F0}) $display("FAIL and_result got v=%b z=%h exp v=1 z=00f000f0", out_valid, out_z); else pass_cnt++;
    total_cnt++; if ({out_zero, out_err} !== 2'b00) $display("FAIL and_flags got %b exp 00", {out_zero, out_err}); else pass_cnt++;
    send(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001);
    @(negedge clk);
    total_cnt++; if (out_z !== 32'hFFF0FFF0) $display("FAIL or_result got %h exp fff0fff0", out_z); else pass_cnt++;
  endtask

  task automatic test_arith_ops();
    send(32'd5, 32'd5, 3'b110);
    @(negedge clk);
    total_cnt++; if ({out_z, out_zero} !== {32'h0, 1'b1}) $display("FAIL sub_zero got z=%h zero=%b exp 0/1", out_z, out_zero); else pass_cnt++;
    send(32'hFFFFFFFF, 32'd1, 3'b010);
    @(negedge clk);
    total_cnt++; if ({out_z, out_zero} !== {32'h0, 1'b1}) $display("FAIL add_wrap got z=%h zero=%b exp 0/1", out_z, out_zero); else pass_cnt++;
    send(32'hFFFFFFFF, 32'd1, 3'b111);
    @(negedge clk);
    total_cnt++; if (out_z !== 32'd1) $display("FAIL slt_signed got %h exp 1", out_z); else pass_cnt++;
    send(32'd1, 32'hFFFFFFFF, 3'b111);
    @(negedge clk);
    total_cnt++; if (out_z !== 32'd0) $display("FAIL slt_signed_rev got %h exp 0", out_z); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b010; in_a = 32'd1; in_b = 32'd1;
    @(negedge clk);
    in_a = 32'd2; in_b = 32'd2;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b exp 1", in_ready); else pass_cnt++;
    @(negedge clk);
    in_a = 32'd3; in_b = 32'd3;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b exp 0", in_ready); else pass_cnt++;
    repeat (2) begin
      @(negedge clk);
      total_cnt++; if ({out_valid, out_z, in_ready} !== {1'b1, 32'd2, 1'b0}) $display("FAIL bp_hold got v=%b z=%h r=%b exp 1/2/0", out_valid, out_z, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if ({out_valid, out_z, in_ready} !== {1'b1, 32'd4, 1'b1}) $display("FAIL bp_second got v=%b z=%h r=%b exp 1/4/1", out_valid, out_z, in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if ({out_valid, out_z} !== {1'b1, 32'd6}) $display("FAIL bp_third got v=%b z=%h exp 1/6", out_valid, out_z); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_unsupported();
    send(32'h12345678, 32'h9ABCDEF0, 3'b011);
    @(negedge clk);
    total_cnt++; if ({out_z, out_err, out_zero} !== {32'h0, 1'b1, 1'b1}) $display("FAIL bad_op got z=%h err=%b zero=%b exp 0/1/1", out_z, out_err, out_zero); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b000; in_a = 32'hAA; in_b = 32'hFF;
    repeat (2) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_mid_full got %b exp 0", in_ready); else pass_cnt++;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rst_mid got v=%b r=%b exp 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

`ifdef OVERFLOW_DETECT_EN
  task automatic test_overflow();
    send(32'h7FFFFFFF, 32'd1, 3'b010);
    @(negedge clk);
    total_cnt++; if ({out_z, out_ovf} !== {32'h80000000, 1'b1}) $display("FAIL ovf_add got z=%h ovf=%b exp 80000000/1", out_z, out_ovf); else pass_cnt++;
    send(32'h80000000, 32'd1, 3'b110);
    @(negedge clk);
    total_cnt++; if (out_ovf !== 1'b1) $display("FAIL ovf_sub got %b exp 1", out_ovf); else pass_cnt++;
    send(32'd3, 32'd1, 3'b110);
    @(negedge clk);
    total_cnt++; if (out_ovf !== 1'b0) $display("FAIL ovf_none got %b exp 0", out_ovf); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic [W+2:0] e;
    logic [2:0] ops[8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b010};
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a  = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      in_b  = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
      in_op = ops[$urandom_range(0, 7)];
      total_cnt++; if (in_ready !== (exp_q.size() < 2)) $display("FAIL rnd_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_q.size() < 2); else pass_cnt++;
      total_cnt++; if (out_valid !== (exp_q.size() > 0)) $display("FAIL rnd_out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_q.size() > 0); else pass_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        total_cnt++; if ({out_err, out_zero, out_z} !== e[W+1:0]) $display("FAIL rnd_data cyc=%0d got %b_%b_%h exp %b_%b_%h", cyc, out_err, out_zero, out_z, e[W+1], e[W], e[W-1:0]); else pass_cnt++;
`ifdef OVERFLOW_DETECT_EN
        total_cnt++; if (out_ovf !== e[W+2]) $display("FAIL rnd_ovf cyc=%0d got %b exp %b", cyc, out_ovf, e[W+2]); else pass_cnt++;
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_q.size() < 2 + (out_ready && exp_q.size() == 2 ? 1 : 0) && in_ready)
        exp_q.push_back(model(in_a, in_b, in_op));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rnd_drain got %b exp 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_logic_ops();
    test_arith_ops();
    test_back_to_back();
    test_unsupported();
    test_reset_mid();
`ifdef OVERFLOW_DETECT_EN
    test_overflow();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage wrapping the 32-bit ALU datapath (and/or/add/sub/slt) with valid/ready handshakes on both sides.
- Upstream, decode presents operands plus a 3-bit op. Downstream, writeback consumes the result, zero flag and error flag.
- A 2-entry skid buffer decouples backpressure, so the upstream `in_ready` never depends combinationally on `out_ready`.
- Sits between decode and writeback in the single-clock datapath.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a valid operation
- in_ready  output  1  stage can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation code
- out_valid  output  1  result available at head of buffer
- out_ready  input  1  downstream accepts head this cycle
- out_z  output  WIDTH  result
- out_zero  output  1  1 when out_z == 0
- out_err  output  1  1 when the op was unsupported
- out_ovf  output  1  signed overflow; present only with OVERFLOW_DETECT_EN

Behaviour:
- Clock/reset: one clock `clk`; reset is synchronous, active-high, port `reset`.
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `out_z`=0, `out_zero`=0, `out_err`=0, `out_ovf`=0.
  - Reset asserted mid-operation discards all buffered results, including any transfer attempted that cycle.
- Op decode:
  - 000: `a & b`
  - 001: `a | b`
  - 010: `a + b` mod 2^WIDTH
  - 110: `a + ~b + 1` mod 2^WIDTH
  - 111: slt, signed; result = `{WIDTH-1 zeros, (a<b signed)}`
  - Any other code: result 0, `out_err`=1.
- `out_zero`:
  - Computed from the stored result.
  - An unsupported op therefore reports `out_zero`=1 and `out_err`=1.
- Handshakes:
  - Input accept = `in_valid && in_ready`.
  - Output pop = `out_valid && out_ready`.
  - Computation is combinational from the inputs; result, zero, err (and ovf) are captured into the buffer on accept.
- Latency:
  - An accepted op appears on `out_*` with `out_valid`=1 on the cycle after the accepting edge.
  - Full throughput: one op per cycle when `out_ready` is held 1.
- FSM on buffer occupancy:
  - States: EMPTY, ONE, TWO.
  - EMPTY, accept → ONE.
  - ONE, accept and no pop → TWO.
  - ONE, pop and no accept → EMPTY.
  - ONE, accept and pop in the same cycle → stays ONE; the new entry replaces the head.
  - TWO, pop → ONE; the second entry moves to head. No accept is possible in TWO.
  - All other combinations hold state.
- `in_ready`: registered output, equal to (next state != TWO). Never a combinational function of `out_ready`.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Output stability: while `out_valid`=1 and `out_ready`=0, all `out_*` hold stable.
- Inputs ignored when `in_ready`=0, regardless of `in_valid`.

Optional Feature:
- OVERFLOW_DETECT_EN defined:
  - `out_ovf` port exists and is stored per entry.
  - For 010: 1 when a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - For 110: 1 when a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - 0 for all other ops; reset 0.
- Undefined: no `out_ovf` port and no related storage; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, then released with `in_valid`=0 → `out_valid`=0, `in_ready`=1, `out_z`=0.
- a=0xF0F0F0F0, b=0x0FF00FF0, op=000, `out_ready`=1 → next cycle `out_z`=0x00F000F0, `out_zero`=0, `out_err`=0. Same operands with op=001 → 0xFFF0FFF0.
- a=5, b=5, op=110 → `out_z`=0, `out_zero`=1. a=0xFFFFFFFF, b=1, op=010 → `out_z`=0, `out_zero`=1. a=0xFFFFFFFF (-1), b=1, op=111 → `out_z`=1.
- `out_ready`=0, issue 3 back-to-back ops (op=010, a=1,b=1 / a=2,b=2 / a=3,b=3) → first two accepted, `in_ready`=0 after second, third held. Raise `out_ready` → outputs 2, 4, 6 in order, no loss.
- op=011 → `out_z`=0, `out_err`=1, `out_zero`=1. Assert reset while 2 entries are buffered → next cycle `out_valid`=0, `in_ready`=1.
- With OVERFLOW_DETECT_EN: a=0x7FFFFFFF, b=1, op=010 → `out_z`=0x80000000, `out_ovf`=1. a=0x80000000, b=1, op=110 → `out_ovf`=1. a=3, b=1, op=110 → `out_ovf`=0.
